// File: rtl/ule_threshold_monitor.sv
// Debounced LO/HI zone monitor fed by unsigned less-or-equal compares.
// Define ULE_THRESHOLD_MONITOR_CROSS_CNT_EN to add a saturating RISE counter.
module ule_threshold_monitor #(
   parameter int WIDTH    = 2,
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 4
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             CE,
   input  logic             VALID,
   input  logic [WIDTH-1:0] I,
   input  logic [WIDTH-1:0] LO,
   input  logic [WIDTH-1:0] HI,
   output logic             BELOW,
   output logic             ABOVE,
   output logic             RISE,
   output logic             FALL,
`ifdef ULE_THRESHOLD_MONITOR_CROSS_CNT_EN
   output logic             ERR,
   output logic [7:0]       CROSS_CNT
`else
   output logic             ERR
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_MID  = 2'd2,
      ST_HIGH = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE);

   state_t           state_q, state_d;
   state_t           cand_q, cand_d;
   state_t           zone;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_nxt;
   logic             below_q, below_d;
   logic             above_q, above_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             err_q, err_d;
   logic             accept;
   logic             i_le_lo;
   logic             i_le_hi;
   logic             lo_le_hi;

   assign accept   = VALID & CE;
   assign i_le_lo  = (I <= LO);
   assign i_le_hi  = (I <= HI);
   assign lo_le_hi = (LO <= HI);

   always_comb begin
      zone = ST_MID;
      if (i_le_lo) begin
         zone = ST_LOW;
      end else if (!i_le_hi) begin
         zone = ST_HIGH;
      end
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      cnt_nxt = '0;
      if (accept && !lo_le_hi) begin
         err_d = 1'b1;
      end else if (accept) begin
         if (state_q == ST_IDLE) begin
            state_d = zone;
            cnt_d   = '0;
         end else if (zone == state_q) begin
            cnt_d = '0;
         end else begin
            if (zone == cand_q) begin
               cnt_nxt = cnt_q + 1'b1;
            end else begin
               cnt_nxt = CNT_W'(1);
            end
            cand_d = zone;
            cnt_d  = cnt_nxt;
            // Commit the zone change once enough agreeing samples arrive.
            if (cnt_nxt >= DEB) begin
               state_d = zone;
               cnt_d   = '0;
               rise_d  = (zone == ST_HIGH);
               fall_d  = (zone == ST_LOW);
            end
         end
      end
      below_d = (state_d == ST_LOW);
      above_d = (state_d == ST_HIGH);
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q <= ST_IDLE;
         cand_q  <= ST_IDLE;
         cnt_q   <= '0;
         below_q <= 1'b0;
         above_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         below_q <= below_d;
         above_q <= above_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         err_q   <= err_d;
      end
   end

   assign BELOW = below_q;
   assign ABOVE = above_q;
   assign RISE  = rise_q;
   assign FALL  = fall_q;
   assign ERR   = err_q;

`ifdef ULE_THRESHOLD_MONITOR_CROSS_CNT_EN
   logic [7:0] xcnt_q, xcnt_d;

   always_comb begin
      xcnt_d = xcnt_q;
      if (rise_d && (xcnt_q != 8'hFF)) begin
         xcnt_d = xcnt_q + 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         xcnt_q <= '0;
      end else begin
         xcnt_q <= xcnt_d;
      end
   end

   assign CROSS_CNT = xcnt_q;
`endif

endmodule
